// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade telemetry transmitter:
// FSM/debug state codes, frame characters, parity modes and hex encoding.
package sga_pkg;

    localparam int FRAME_LEN = 15;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Codes shown on db_state; START..STOP come from the character shifter
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam logic [7:0] CH_H    = 8'h48;
    localparam logic [7:0] CH_A    = 8'h41;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_L    = 8'h4C;
    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_HASH = 8'h23;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
    endfunction

endpackage

// File: rtl/sga_uart_char_tx.sv
// One-character UART shifter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Handshake: a character is taken on a cycle where valid and ready are both high; ready is high only while idle.
module sga_uart_char_tx
    import sga_pkg::*;
#(
    parameter int BIT_CYC = 434,
    parameter int PARITY  = PARITY_NONE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       last,
    output logic [2:0] phase,
    output logic       line
);
    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [2:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          bit_end;

    assign bit_end = (baud == CW'(BIT_CYC - 1));
    assign ready   = (state == ST_IDLE);
    assign last    = (state == ST_STOP) && bit_end;
    assign phase   = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            line    <= 1'b1;
        end else begin
            baud <= (state == ST_IDLE || bit_end) ? '0 : baud + CW'(1);

            // The line lags the state by one cycle so it is driven from a flop.
            case (state)
                ST_START:  line <= 1'b0;
                ST_DATA:   line <= shift[0];
                ST_PARITY: line <= par_bit;
                default:   line <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        state   <= ST_START;
                        shift   <= data;
                        bit_idx <= '0;
                        par_bit <= (PARITY == PARITY_ODD) ? ~^data : ^data;
                    end
                end
                ST_START: if (bit_end) state <= ST_DATA;
                ST_DATA: begin
                    if (bit_end) begin
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
                ST_PARITY: if (bit_end) state <= ST_STOP;
                ST_STOP:   if (bit_end) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sga_telemetry_tx.sv
// Game telemetry transmitter: snapshots the game state and sends it as a 15-character
// ASCII frame "HxyAxySssLssFf#" on request or periodically in auto mode.
module sga_telemetry_tx
    import sga_pkg::*;
#(
    parameter int COORD_W    = 3,
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int PERIOD_CYC = 5_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 auto_en,
    input  logic                 abort,
    input  logic [2*COORD_W-1:0] head,
    input  logic [2*COORD_W-1:0] apple,
    input  logic [5:0]           game_state,
    input  logic [5:0]           size,
    input  logic [2:0]           flags,
    input  logic                 ate_apple,
    output logic                 saida_serial,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [2:0]           db_state
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int PW      = $clog2(PERIOD_CYC + 1);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_LOAD = 2'd1;
    localparam logic [1:0] F_SEND = 2'd2;

    logic [1:0]           fsm;
    logic [3:0]           idx;
    logic [PW-1:0]        period;
    logic                 abort_pend;
    logic [2*COORD_W-1:0] head_q, apple_q;
    logic [5:0]           gs_q, size_q;
    logic [2:0]           flags_q;
    logic                 ate_q;

    logic       tx_ready, tx_last;
    logic [2:0] tx_phase;
    logic [7:0] cur_char;
    logic       trigger, last_char, stop_here, frame_end;

    assign trigger   = start || (auto_en && period == PW'(PERIOD_CYC - 1));
    assign last_char = (idx == 4'(FRAME_LEN - 1));
    assign stop_here = last_char || abort_pend || abort;
    assign frame_end = (fsm == F_SEND) && tx_last && stop_here;
    assign busy      = (fsm != F_IDLE);

    always_comb begin
        case (fsm)
            F_IDLE:  db_state = ST_IDLE;
            F_LOAD:  db_state = ST_LOAD;
            default: db_state = tx_phase;
        endcase
    end

    // Coordinates are zero-extended to a full hex digit
    always_comb begin
        cur_char = CH_HASH;
        case (idx)
            4'd0:    cur_char = CH_H;
            4'd1:    cur_char = hex_ascii(4'(head_q[COORD_W-1:0]));
            4'd2:    cur_char = hex_ascii(4'(head_q[2*COORD_W-1:COORD_W]));
            4'd3:    cur_char = CH_A;
            4'd4:    cur_char = hex_ascii(4'(apple_q[COORD_W-1:0]));
            4'd5:    cur_char = hex_ascii(4'(apple_q[2*COORD_W-1:COORD_W]));
            4'd6:    cur_char = CH_S;
            4'd7:    cur_char = hex_ascii({2'b00, gs_q[5:4]});
            4'd8:    cur_char = hex_ascii(gs_q[3:0]);
            4'd9:    cur_char = CH_L;
            4'd10:   cur_char = hex_ascii({2'b00, size_q[5:4]});
            4'd11:   cur_char = hex_ascii(size_q[3:0]);
            4'd12:   cur_char = CH_F;
            4'd13:   cur_char = hex_ascii({ate_q, flags_q});
            default: cur_char = CH_HASH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm        <= F_IDLE;
            idx        <= '0;
            period     <= '0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            head_q     <= '0;
            apple_q    <= '0;
            gs_q       <= '0;
            size_q     <= '0;
            flags_q    <= '0;
            ate_q      <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            if ((fsm == F_IDLE && trigger) || !auto_en)
                period <= '0;
            else if (fsm == F_IDLE)
                period <= period + PW'(1);

            // Abort is only remembered while a frame is in flight
            if (fsm == F_IDLE || frame_end)
                abort_pend <= 1'b0;
            else if (abort)
                abort_pend <= 1'b1;

            case (fsm)
                F_IDLE: begin
                    if (trigger) begin
                        fsm     <= F_LOAD;
                        idx     <= '0;
                        head_q  <= head;
                        apple_q <= apple;
                        gs_q    <= game_state;
                        size_q  <= size;
                        flags_q <= flags;
                        ate_q   <= ate_apple;
                    end
                end
                F_LOAD: if (tx_ready) fsm <= F_SEND;
                F_SEND: begin
                    if (tx_last) begin
                        if (stop_here) begin
                            fsm     <= F_IDLE;
                            done    <= last_char;
                            aborted <= !last_char;
                        end else begin
                            fsm <= F_LOAD;
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: fsm <= F_IDLE;
            endcase
        end
    end

    sga_uart_char_tx #(
        .BIT_CYC (BIT_CYC),
        .PARITY  (PARITY)
    ) u_char_tx (
        .clock (clock),
        .reset (reset),
        .valid (fsm == F_LOAD),
        .ready (tx_ready),
        .data  (cur_char),
        .last  (tx_last),
        .phase (tx_phase),
        .line  (saida_serial)
    );

endmodule

// File: tb/tb_sga_telemetry_tx.sv
// Directed bench for sga_telemetry_tx: three instances (no/even/odd parity) at BIT_CYC=10,
// frames decoded from the serial line and compared against hand-written expected strings.
module tb_sga_telemetry_tx;

    localparam int BIT = 10;

    logic       clock;
    logic       reset;
    logic       start0, start1, start2;
    logic       auto_en, abort;
    logic [5:0] head, apple, gs, size;
    logic [2:0] flags;
    logic       ate;

    logic [2:0] ser, busy, done, aborted;
    logic [2:0] dbs0, dbs1, dbs2;

    int n_cmp;
    int n_err;
    int cyc;
    int done_cnt[3];
    int done_cyc[3];
    int ab_cnt[3];
    int ab_cyc[3];
    logic [7:0] exp_q[$];
    bit scr_on;

    sga_telemetry_tx #(.COORD_W(3), .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(0), .PERIOD_CYC(200)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .auto_en(auto_en), .abort(abort),
        .head(head), .apple(apple), .game_state(gs), .size(size), .flags(flags), .ate_apple(ate),
        .saida_serial(ser[0]), .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .db_state(dbs0));

    sga_telemetry_tx #(.COORD_W(3), .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(1), .PERIOD_CYC(200)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .auto_en(1'b0), .abort(1'b0),
        .head(head), .apple(apple), .game_state(gs), .size(size), .flags(flags), .ate_apple(ate),
        .saida_serial(ser[1]), .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .db_state(dbs1));

    sga_telemetry_tx #(.COORD_W(3), .CLK_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .PERIOD_CYC(200)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .auto_en(1'b0), .abort(1'b0),
        .head(head), .apple(apple), .game_state(gs), .size(size), .flags(flags), .ate_apple(ate),
        .saida_serial(ser[2]), .busy(busy[2]), .done(done[2]), .aborted(aborted[2]), .db_state(dbs2));

    // ---------------- clock / cycle counter / pulse monitor ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_cyc[i] <= cyc;
            end
            if (aborted[i]) begin
                ab_cnt[i] <= ab_cnt[i] + 1;
                ab_cyc[i] <= cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // ---------------- driver / receiver tasks ----------------
    task automatic pulse_start(input int w, output int k);
        @(negedge clock);
        case (w)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clock);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        k = cyc;
    endtask

    task automatic wait_low(input int w, input int bound, output int at, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        at = 0;
        while (!ok && n < bound) begin
            @(negedge clock);
            n++;
            if (ser[w] == 1'b0) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic wait_done(input int w, input int prev, input int bound, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < bound) begin
            @(negedge clock);
            n++;
            if (done_cnt[w] != prev) ok = 1'b1;
        end
    endtask

    task automatic rx_char(input int w, input bit has_par, output logic [7:0] d,
                           output logic p, output logic stp, output int at, output bit ok);
        d = '0;
        p = 1'b0;
        stp = 1'b0;
        wait_low(w, 400, at, ok);
        if (!ok) return;
        repeat (BIT / 2) @(negedge clock);
        for (int b = 0; b < 8; b++) begin
            repeat (BIT) @(negedge clock);
            d[b] = ser[w];
        end
        if (has_par) begin
            repeat (BIT) @(negedge clock);
            p = ser[w];
        end
        repeat (BIT) @(negedge clock);
        stp = ser[w];
    endtask

    task automatic rx_frame(input int w, input int par, input string tag, output int first_low);
        logic [7:0] d, e;
        logic p, stp;
        int at;
        bit ok;
        first_low = 0;
        for (int i = 0; i < 15; i++) begin
            rx_char(w, par != 0, d, p, stp, at, ok);
            if (!ok) begin
                check($sformatf("%s_timeout_c%0d", tag, i), 32'd0, 32'd1);
                exp_q.delete();
                return;
            end
            if (i == 0) first_low = at;
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d", tag, i), d, e);
            if (par == 1) check($sformatf("%s_par%0d", tag, i), p, ^e);
            if (par == 2) check($sformatf("%s_par%0d", tag, i), p, ~^e);
            check($sformatf("%s_stop%0d", tag, i), stp, 1);
        end
    endtask

    task automatic set_game_inputs();
        head  = 6'b101_011;
        apple = 6'b000_111;
        gs    = 6'h0D;
        size  = 6'd12;
        flags = 3'b101;
        ate   = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k, fl, prev, prev_a, d1, d2, l2, l3, lows, at;
        bit ok;

        reset   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        auto_en = 1'b0;
        abort   = 1'b0;
        scr_on  = 1'b0;
        set_game_inputs();

        repeat (3) @(negedge clock);
        check("rst_line", ser[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_aborted", aborted[0], 0);
        check("rst_db_state", dbs0, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Basic frame, no parity
        push_frame("H35A70S0DL0CFD#");
        prev = done_cnt[0];
        pulse_start(0, k);
        check("t1_db_load", dbs0, 1);
        check("t1_busy", busy[0], 1);
        @(negedge clock);
        check("t1_db_start", dbs0, 2);
        check("t1_line_high_k1", ser[0], 1);
        rx_frame(0, 0, "t1", fl);
        check("t1_first_low", fl - k, 2);
        wait_done(0, prev, 100, ok);
        check("t1_done_seen", ok, 1);
        check("t1_done_cyc", done_cyc[0] - k, 1515);
        @(negedge clock);
        check("t1_busy_end", busy[0], 0);
        check("t1_db_idle", dbs0, 0);

        // Even parity
        push_frame("H35A70S0DL0CFD#");
        prev = done_cnt[1];
        pulse_start(1, k);
        rx_frame(1, 1, "even", fl);
        wait_done(1, prev, 100, ok);
        check("even_done_seen", ok, 1);
        check("even_done_cyc", done_cyc[1] - k, 15 * 111);

        // Odd parity
        push_frame("H35A70S0DL0CFD#");
        prev = done_cnt[2];
        pulse_start(2, k);
        rx_frame(2, 2, "odd", fl);
        wait_done(2, prev, 100, ok);
        check("odd_done_seen", ok, 1);
        check("odd_done_cyc", done_cyc[2] - k, 15 * 111);

        // Abort during the data bits of char index 4 ('7' = 0x37)
        repeat (5) @(negedge clock);
        prev   = done_cnt[0];
        prev_a = ab_cnt[0];
        pulse_start(0, k);
        while (cyc < k + 430) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        while (cyc < k + 520) begin
            @(negedge clock);
            if (cyc == k + 470) check("ab_c4_bit5", ser[0], 1);
            if (cyc == k + 490) check("ab_c4_bit7", ser[0], 0);
            if (cyc == k + 500) check("ab_c4_stop", ser[0], 1);
        end
        check("ab_pulses", ab_cnt[0] - prev_a, 1);
        check("ab_cyc", ab_cyc[0] - k, 505);
        check("ab_no_done", done_cnt[0] - prev, 0);
        check("ab_busy", busy[0], 0);
        check("ab_db_idle", dbs0, 0);
        lows = 0;
        repeat (300) begin
            @(negedge clock);
            if (ser[0] == 1'b0) lows++;
        end
        check("ab_line_quiet", lows, 0);

        // Auto mode, with an ignored start pulse mid-frame
        prev = done_cnt[0];
        auto_en = 1'b1;
        wait_done(0, prev, 3000, ok);
        check("auto_f1_done", ok, 1);
        d1 = done_cyc[0];
        wait_low(0, 400, l2, ok);
        check("auto_f2_seen", ok, 1);
        check("auto_gap1", l2 - d1, 202);
        while (cyc < l2 + 300) @(negedge clock);
        prev = done_cnt[0];
        pulse_start(0, k);
        wait_done(0, prev, 2000, ok);
        check("auto_f2_done", ok, 1);
        d2 = done_cyc[0];
        check("auto_f2_len", d2 - (l2 - 2), 1515);
        wait_low(0, 400, l3, ok);
        check("auto_f3_seen", ok, 1);
        check("auto_gap2", l3 - d2, 202);
        auto_en = 1'b0;
        prev = done_cnt[0];
        wait_done(0, prev, 2000, ok);
        check("auto_f3_done", ok, 1);
        wait_low(0, 400, at, ok);
        check("auto_off_quiet", ok, 0);

        // Snapshot: inputs scrambled every cycle while the frame is in flight
        head  = 6'b010_110;
        apple = 6'b111_001;
        gs    = 6'h2A;
        size  = 6'd63;
        flags = 3'b011;
        ate   = 1'b0;
        push_frame("H62A17S2AL3FF3#");
        prev = done_cnt[0];
        pulse_start(0, k);
        scr_on = 1'b1;
        fork
            begin
                rx_frame(0, 0, "snap", fl);
                scr_on = 1'b0;
            end
            begin
                while (scr_on) begin
                    @(negedge clock);
                    head  = 6'($urandom_range(0, 63));
                    apple = 6'($urandom_range(0, 63));
                    gs    = 6'($urandom_range(0, 63));
                    size  = 6'($urandom_range(0, 63));
                    flags = 3'($urandom_range(0, 7));
                    ate   = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_done(0, prev, 100, ok);
        check("snap_done", ok, 1);

        // Asynchronous reset in the middle of the start bit, then a clean frame
        set_game_inputs();
        repeat (3) @(negedge clock);
        pulse_start(0, k);
        while (cyc < k + 6) @(negedge clock);
        check("mid_rst_pre_low", ser[0], 0);
        reset = 1'b0;
        #1;
        check("mid_rst_line", ser[0], 1);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_db", dbs0, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        push_frame("H35A70S0DL0CFD#");
        prev = done_cnt[0];
        pulse_start(0, k);
        rx_frame(0, 0, "post_rst", fl);
        check("post_rst_first_low", fl - k, 2);
        wait_done(0, prev, 100, ok);
        check("post_rst_done", ok, 1);
        check("post_rst_done_cyc", done_cyc[0] - k, 1515);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sga_telemetry_tx.md
# sga_telemetry_tx

Parametrised game-telemetry UART transmitter for the Snake Game Arcade. It snapshots the game state: head, apple, FSM state, snake size, mode/velocity/difficulty flags and apple-eaten flag. It then serialises that snapshot as a fixed 15-character ASCII frame on one line. Frames go out on an explicit request or periodically in auto mode, with configurable baud, parity, board coordinate width and mid-frame abort. It sits beside the game UC/FD in the top level, drives the serial output pin, and replaces the fixed-format transmitter pair.

## Interface
- `COORD_W`, 3: bits per coordinate (legal 1..4); head/apple buses are 2*COORD_W bits, X in low half, Y in high half
- `CLK_HZ`, 50_000_000: clock frequency
- `BAUD`, 115200: line rate; BIT_CYC = CLK_HZ/BAUD (integer, must be ≥2)
- `PARITY`, 0: 0 none, 1 even, 2 odd
- `PERIOD_CYC`, 5_000_000: auto-mode gap, counted from end of previous frame
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: frame request, sampled in IDLE only
- `auto_en` in 1: level; enables periodic frames
- `abort` in 1: level/pulse; ends frame after current character
- `head` in 2*COORD_W: snake head coordinate
- `apple` in 2*COORD_W: apple coordinate
- `game_state` in 6: game UC state code
- `size` in 6: snake length
- `flags` in 3: {mode, velocity, difficulty}
- `ate_apple` in 1: apple-eaten flag
- `saida_serial` out 1: UART line, idle high
- `busy` out 1: high from accept to frame end
- `done` out 1: one-cycle pulse, frame completed normally
- `aborted` out 1: one-cycle pulse, frame cut by abort
- `db_state` out 3: FSM state code for hex display

## Operation
- Reset values: saida_serial=1, busy=0, done=0, aborted=0, db_state=0 (IDLE), period counter=0, char index=0.
- Trigger: in IDLE, `start`=1 or (`auto_en`=1 and period counter reached PERIOD_CYC-1). Start and auto in the same cycle produce one frame and clear the period counter. `start` while busy is ignored; it is not queued.
- On accept, all inputs are snapshotted into registers. The frame uses only the snapshot, even if inputs change.
- Frame, 15 chars, in order:
  - 'H', hex(headX), hex(headY)
  - 'A', hex(appleX), hex(appleY)
  - 'S', hex(game_state[5:4]), hex(game_state[3:0])
  - 'L', hex(size[5:4]), hex(size[3:0])
  - 'F', hex({ate_apple, flags})
  - '#'
- hex() gives ASCII '0'-'9', 'A'-'F' (uppercase). Coordinates are zero-extended to 4 bits.
- Character format: start bit 0, 8 data bits LSB first, then parity if PARITY≠0 (even: XOR of data bits; odd: its inverse), then 1 stop bit of 1.
- FSM states and db_state codes:
  - IDLE=0, LOAD=1, START=2, DATA=3, PARITY=4, STOP=5.
  - IDLE→LOAD on trigger.
  - LOAD (1 cycle, fetch char[index]) → START.
  - START → DATA.
  - DATA (8 bits) → PARITY, or → STOP when PARITY=0.
  - PARITY → STOP.
  - STOP → LOAD if index<14 and no pending abort; otherwise → IDLE.
- Abort: `abort` seen high in any non-IDLE cycle sets a pending flag. The current character completes including its stop bit, then the FSM goes to IDLE, pulses `aborted` and does not pulse `done`. Abort in IDLE is ignored. Abort and start in the same IDLE cycle: the frame starts and abort is ignored.
- Period counter: counts only in IDLE with auto_en=1; it clears on any frame accept and whenever auto_en=0. Deasserting auto_en mid-frame does not stop the current frame.
- Reset mid-frame: saida_serial returns to 1 immediately (asynchronously) and all state returns to reset values.

## Timing
- Edge k samples a trigger → LOAD during k..k+1 → saida_serial low from edge k+2 (registered output).
- Each bit lasts exactly BIT_CYC cycles.
- Each character lasts 1 + (10 or 11)×BIT_CYC cycles (LOAD plus bits).
- Frame length is 15×(1 + NB×BIT_CYC), where NB = 10 or 11.
- `done`/`aborted` are high the cycle after the final stop bit ends, concurrent with the IDLE entry. `busy` falls on that same edge.
- The earliest next manual frame is accepted the cycle `busy` is low.

## Structure
- Shared package `sga_pkg`: FSM state encoding, ASCII constants ('H','A','S','L','F','#'), FRAME_LEN=15, PARITY_* encodings, hex-to-ASCII function.
- Sub-module `sga_uart_char_tx`: one-character shifter with baud counter, parity and start/stop framing, plus a valid/ready handshake. The top holds the snapshot, character mux, frame index, period counter and abort logic.

## Test plan
- CLK_HZ=1_000_000, BAUD=100_000 (BIT_CYC=10), PARITY=0, COORD_W=3. Inputs: head=6'b101_011, apple=6'b000_111, game_state=6'h0D, size=12, flags=3'b101, ate_apple=1. Pulse start → decoded frame "H35A70S0DL0CFD#", done after 15×101=1515 cycles, line low at start edge+2.
- Same setup with PARITY=1 and then PARITY=2: the parity bit of each char is correct (for 'H'=0x48: even→0, odd→1), and the frame lasts 15×111 cycles.
- Abort pulsed during the data bits of char 4 → char 4 finishes with its stop bit, then IDLE, `aborted`=1 for one cycle, no `done`, and the line stays high.
- auto_en=1 with PERIOD_CYC=200 → successive frames start exactly 200+2 cycles after each `done`. A start pulse mid-frame produces no extra frame.
- Inputs changed every cycle during a frame → the transmitted frame still matches the snapshot taken at accept.
- reset low mid-bit → saida_serial=1, busy=0, db_state=0 immediately. After release, a new start produces a full, correct frame.
